// File: rtl/enum_type.sv
// -----------------------------------------------------------------------------
// enum_type
// Shared type and constant package for the tick timer bank.
//   tick_mode_t  : per-channel mode, ONE_SHOT or PERIODIC
//   chan_state_t : per-channel FSM state, IDLE or RUN
//   SEC_TICK     : default clock cycles per second for the seconds countdown
//   COUNT_SEC    : default seconds countdown load value
// -----------------------------------------------------------------------------
package enum_type;

   typedef enum logic {
      ONE_SHOT = 1'b0,
      PERIODIC = 1'b1
   } tick_mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } chan_state_t;

   localparam int SEC_TICK  = 25_000_000;
   localparam int COUNT_SEC = 60;

endpackage

// File: rtl/tick_chan.sv
// -----------------------------------------------------------------------------
// tick_chan
// One timer channel: IDLE/RUN FSM with a down-counter.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : start/restart request (wins over stop)
//   stop         : return to IDLE, suppressing any tick this cycle
//   mode         : 0 one-shot, 1 periodic (latched at start)
//   period       : period in cycles, 0 treated as 1 (sampled at every reload)
//   pause        : freeze counter and state, suppress tick
//   tick         : one-cycle expiry pulse
//   busy         : channel is in RUN
// -----------------------------------------------------------------------------
module tick_chan
   import enum_type::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [CNT_W-1:0] period,
   input  logic             pause,
   output logic             tick,
   output logic             busy
);

   chan_state_t      state_q, state_d;
   tick_mode_t       mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] reload;

   // Loading P-1 and ticking at zero gives exactly P cycles per expiry;
   // period 0 collapses to the same load as period 1.
   assign reload = (period == '0) ? '0 : period - CNT_W'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         mode_q  <= ONE_SHOT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      tick    = 1'b0;
      if (start) begin
         // Restart takes priority over stop and hides a coincident expiry.
         state_d = RUN;
         mode_d  = tick_mode_t'(mode);
         cnt_d   = reload;
      end else if (stop) begin
         state_d = IDLE;
      end else if (state_q == RUN && !pause) begin
         if (cnt_q == '0) begin
            tick = 1'b1;
            if (mode_q == PERIODIC) begin
               cnt_d = reload;
            end else begin
               state_d = IDLE;
            end
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   assign busy = (state_q == RUN);

endmodule

// File: rtl/tick_timer_bank.sv
// -----------------------------------------------------------------------------
// tick_timer_bank
// NCH independent tick channels plus a seconds countdown unit.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start/stop   : per-channel start/restart and stop requests
//   mode         : per-channel 0 one-shot, 1 periodic
//   period       : per-channel period, channel i at [i*CNT_W +: CNT_W]
//   pause        : global freeze of channels and seconds prescaler
//   sec_load     : load seconds countdown with COUNT_SEC
//   tick, busy   : per-channel expiry pulse and RUN indication
//   sec_left     : remaining seconds
//   sec_done     : one-cycle pulse after sec_left reaches 0
// -----------------------------------------------------------------------------
module tick_timer_bank #(
   parameter int NCH       = 4,
   parameter int CNT_W     = 32,
   parameter int SEC_TICK  = enum_type::SEC_TICK,
   parameter int COUNT_SEC = enum_type::COUNT_SEC
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NCH-1:0]       start,
   input  logic [NCH-1:0]       stop,
   input  logic [NCH-1:0]       mode,
   input  logic [NCH*CNT_W-1:0] period,
   input  logic                 pause,
   input  logic                 sec_load,
   output logic [NCH-1:0]       tick,
   output logic [NCH-1:0]       busy,
   output logic [6:0]           sec_left,
   output logic                 sec_done
);

   localparam int              PRE_W    = (SEC_TICK > 1) ? $clog2(SEC_TICK) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SEC_TICK - 1);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      tick_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .start   (start[i]),
         .stop    (stop[i]),
         .mode    (mode[i]),
         .period  (period[i*CNT_W +: CNT_W]),
         .pause   (pause),
         .tick    (tick[i]),
         .busy    (busy[i])
      );
   end

   logic [PRE_W-1:0] pre_q;
   logic [6:0]       sec_q;
   logic             done_q;

   // The prescaler only advances while a countdown is in progress; the
   // done flag is held across a pause so the pulse appears once it lifts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         sec_q  <= '0;
         done_q <= 1'b0;
      end else if (sec_load) begin
         pre_q  <= '0;
         sec_q  <= 7'(COUNT_SEC);
         done_q <= 1'b0;
      end else if (!pause) begin
         done_q <= 1'b0;
         if (sec_q != '0) begin
            if (pre_q == PRE_LAST) begin
               pre_q <= '0;
               sec_q <= sec_q - 7'd1;
               if (sec_q == 7'd1) begin
                  done_q <= 1'b1;
               end
            end else begin
               pre_q <= pre_q + PRE_W'(1);
            end
         end
      end
   end

   assign sec_left = sec_q;
   assign sec_done = done_q & ~pause;

endmodule

// File: tb/tb_tick_timer_bank.sv
module tb_tick_timer_bank;

   localparam int NCH       = 4;
   localparam int CNT_W     = 8;
   localparam int SEC_TICK  = 4;
   localparam int COUNT_SEC = 3;

   typedef struct {
      int cyc;
      int ch;
   } ev_t;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [NCH-1:0]       start, stop, mode;
   logic [NCH*CNT_W-1:0] period;
   logic                 pause, sec_load;
   logic [NCH-1:0]       tick, busy;
   logic [6:0]           sec_left;
   logic                 sec_done;

   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   ev_t tick_q[$];
   int  done_q[$];

   tick_timer_bank #(
      .NCH       (NCH),
      .CNT_W     (CNT_W),
      .SEC_TICK  (SEC_TICK),
      .COUNT_SEC (COUNT_SEC)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .period   (period),
      .pause    (pause),
      .sec_load (sec_load),
      .tick     (tick),
      .busy     (busy),
      .sec_left (sec_left),
      .sec_done (sec_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic at(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_tick(input int c, input int ch);
      ev_t e;
      e.cyc = c;
      e.ch  = ch;
      tick_q.push_back(e);
   endtask

   task automatic set_period(input int ch, input int p);
      period[ch*CNT_W +: CNT_W] = CNT_W'(p);
   endtask

   // Monitor: every tick or sec_done the DUT presents is matched against the
   // oldest expected event, in channel order within a cycle.
   initial begin
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < NCH; ch++) begin
            if (tick[ch]) begin
               if (tick_q.size() == 0) begin
                  chk($sformatf("unexpected_tick_ch%0d", ch), 1, 0);
               end else begin
                  ev_t e;
                  e = tick_q.pop_front();
                  chk("tick_channel", ch, e.ch);
                  chk($sformatf("tick_cycle_ch%0d", ch), cyc, e.cyc);
               end
            end
         end
         if (sec_done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_sec_done", 1, 0);
            end else begin
               int c;
               c = done_q.pop_front();
               chk("sec_done_cycle", cyc, c);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      reset_n  = 1'b0;
      start    = '0;
      stop     = '0;
      mode     = '0;
      period   = '0;
      pause    = 1'b0;
      sec_load = 1'b0;

      at(1);
      chk("reset_tick", int'(tick), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_sec_left", int'(sec_left), 0);
      chk("reset_sec_done", int'(sec_done), 0);
      at(2);
      reset_n = 1'b1;

      // ch0 periodic, period 5
      c = cyc + 2;
      at(c);
      mode[0] = 1'b1; set_period(0, 5); start[0] = 1'b1;
      push_tick(c + 5, 0); push_tick(c + 10, 0); push_tick(c + 15, 0);
      at(c + 1);
      start[0] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         at(c + k);
         chk("p1_busy0", int'(busy[0]), 1);
      end
      at(c + 17); stop[0] = 1'b1;
      at(c + 18); stop[0] = 1'b0;
      chk("p1_busy0_after_stop", int'(busy[0]), 0);
      at(c + 22);
      chk("p1_queue_empty", tick_q.size(), 0);

      // ch1 one-shot period 3, ch2 periodic period 0
      c = cyc + 2;
      at(c);
      mode[1] = 1'b0; set_period(1, 3);
      mode[2] = 1'b1; set_period(2, 0);
      start[1] = 1'b1; start[2] = 1'b1;
      push_tick(c + 1, 2); push_tick(c + 2, 2);
      push_tick(c + 3, 1); push_tick(c + 3, 2);
      push_tick(c + 4, 2); push_tick(c + 5, 2);
      at(c + 1); start = '0;
      at(c + 3); chk("p2_busy1_run", int'(busy[1]), 1);
      at(c + 4); chk("p2_busy1_drop", int'(busy[1]), 0);
      at(c + 6); stop[2] = 1'b1;
      at(c + 7); stop[2] = 1'b0;
      chk("p2_busy2_stop", int'(busy[2]), 0);
      at(c + 10);
      chk("p2_queue_empty", tick_q.size(), 0);

      // ch0 pause delays expiry; stop+start restarts
      c = cyc + 2;
      at(c);
      mode[0] = 1'b1; set_period(0, 5); start[0] = 1'b1;
      push_tick(c + 9, 0);
      at(c + 1); start[0] = 1'b0;
      at(c + 2); pause = 1'b1;
      at(c + 4); chk("p3_busy0_paused", int'(busy[0]), 1);
      at(c + 6); pause = 1'b0;
      at(c + 11); start[0] = 1'b1; stop[0] = 1'b1;
      push_tick(c + 16, 0);
      at(c + 12); start[0] = 1'b0; stop[0] = 1'b0;
      chk("p3_busy0_restart", int'(busy[0]), 1);
      at(c + 17); stop[0] = 1'b1;
      at(c + 18); stop[0] = 1'b0;
      chk("p3_busy0_stop", int'(busy[0]), 0);
      at(c + 20);
      chk("p3_queue_empty", tick_q.size(), 0);

      // ch3 restart at zero hides tick; period change applies at reload
      c = cyc + 2;
      at(c);
      mode[3] = 1'b1; set_period(3, 2); start[3] = 1'b1;
      push_tick(c + 2, 3);
      at(c + 1); start[3] = 1'b0;
      at(c + 4); start[3] = 1'b1;
      push_tick(c + 6, 3); push_tick(c + 9, 3);
      at(c + 5); start[3] = 1'b0; set_period(3, 3);
      at(c + 10); stop[3] = 1'b1;
      at(c + 11); stop[3] = 1'b0;
      chk("p4_busy3_stop", int'(busy[3]), 0);
      at(c + 13);
      chk("p4_queue_empty", tick_q.size(), 0);

      // seconds countdown
      c = cyc + 2;
      at(c);
      sec_load = 1'b1;
      done_q.push_back(c + 13);
      at(c + 1);  sec_load = 1'b0;
      chk("sec_load_3", int'(sec_left), 3);
      at(c + 4);  chk("sec_hold_3", int'(sec_left), 3);
      at(c + 5);  chk("sec_2", int'(sec_left), 2);
      at(c + 9);  chk("sec_1", int'(sec_left), 1);
      at(c + 13); chk("sec_0", int'(sec_left), 0);
      at(c + 20); chk("sec_stays_0", int'(sec_left), 0);
      chk("sec_done_queue_empty", done_q.size(), 0);

      // reload during countdown
      c = cyc + 2;
      at(c);      sec_load = 1'b1;
      at(c + 1);  sec_load = 1'b0;
      at(c + 6);  chk("reload_pre_2", int'(sec_left), 2);
      sec_load = 1'b1;
      done_q.push_back(c + 19);
      at(c + 7);  sec_load = 1'b0;
      chk("reload_3", int'(sec_left), 3);
      at(c + 18); chk("reload_1", int'(sec_left), 1);
      at(c + 19); chk("reload_0", int'(sec_left), 0);
      at(c + 24);
      chk("reload_done_queue_empty", done_q.size(), 0);

      // reset mid-count
      c = cyc + 2;
      at(c);
      mode = '1;
      for (int ch = 0; ch < NCH; ch++) set_period(ch, 7);
      start = '1; sec_load = 1'b1;
      at(c + 1); start = '0; sec_load = 1'b0;
      chk("rst_busy_before", int'(busy), 15);
      at(c + 3);
      reset_n = 1'b0;
      #1;
      chk("rst_tick", int'(tick), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sec_left", int'(sec_left), 0);
      chk("rst_sec_done", int'(sec_done), 0);
      at(c + 5); reset_n = 1'b1;
      at(c + 30);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_sec_left", int'(sec_left), 0);
      chk("post_rst_tick_queue", tick_q.size(), 0);
      chk("post_rst_done_queue", done_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
